fetch_stage: RTL and testbench

Instruction-fetch stage directly upstream of the register-file/ALU/data-memory datapath block. It holds the PC and selects the next PC (sequential, branch, or jalr). It drives the instruction-memory address and captures the fetched word into an IF/ID register. That register supplies Instr_D, PC_D and PCPlus4_D to decode and to the datapath's PCPlus4 input. Stall, flush and redirect-squash are handled here.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_stage_if_id_reg.sv | 41 ++++
 rtl/fetch_stage.sv | 124 ++++++++++++
 tb/tb_fetch_stage.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared encodings for the instruction-fetch stage: next-PC select codes,
// fetch FSM states and the bubble instruction word.
package fetch_pkg;

  // Next-PC select codes driven by the decode/execute control logic.
  // Code 2'b11 is not listed and behaves like PC_SEQ.
  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JALR   = 2'b10
  } pc_src_e;

  // S_BOOT covers the single cycle after reset release, when the word at
  // the reset vector is captured unconditionally.
  typedef enum logic [0:0] {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } fetch_state_e;

  // addi x0,x0,0
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: captures fetched instruction, its PC and PC+4.
// Priority: reset > bubble > load > hold. A bubble replaces the instruction
// with the NOP word and clears valid, while PC/PC+4 keep their old values.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(NOP_WORD)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  bubble,
  input  logic [DATA_WIDTH-1:0] instr_in,
  input  logic [DATA_WIDTH-1:0] pc_in,
  input  logic [DATA_WIDTH-1:0] pcplus4_in,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] pcplus4,
  output logic                  valid
);

  // Register update with load/hold/bubble control.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr   <= NOP_INSTR;
      pc      <= '0;
      pcplus4 <= '0;
      valid   <= 1'b0;
    end else if (bubble) begin
      instr   <= NOP_INSTR;
      valid   <= 1'b0;
    end else if (load) begin
      instr   <= instr_in;
      pc      <= pc_in;
      pcplus4 <= pcplus4_in;
      valid   <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection (sequential,
// branch, jalr), boot FSM, misaligned-target flag and the IF/ID register.
// Optional macro FETCH_PERF_CNT_EN adds PerfFetched/PerfBubbles counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(32'hBFC0_0000),
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(NOP_WORD)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            PCSrc,
  input  logic [DATA_WIDTH-1:0] ImmExt,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic                  stall,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] IMemAddr,
  input  logic [DATA_WIDTH-1:0] IMemData,
  output logic [DATA_WIDTH-1:0] Instr_D,
  output logic [DATA_WIDTH-1:0] PC_D,
  output logic [DATA_WIDTH-1:0] PCPlus4_D,
  output logic                  Valid_D,
  output logic                  Misalign
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [DATA_WIDTH-1:0] PerfFetched,
  output logic [DATA_WIDTH-1:0] PerfBubbles
`endif
);

  fetch_state_e          state_reg;
  logic [DATA_WIDTH-1:0] pc_reg;
  logic [DATA_WIDTH-1:0] pc_next;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] target;
  logic                  redirect;
  logic                  if_load;
  logic                  if_bubble;
  logic                  misalign_next;

  assign IMemAddr = pc_reg;
  assign pc_plus4 = pc_reg + DATA_WIDTH'(4);

  // Redirect target selection; jalr clears bit 0 of the ALU result.
  always_comb begin
    target   = pc_plus4;
    redirect = 1'b0;
    if (PCSrc == PC_BRANCH) begin
      target   = PC_D + ImmExt;
      redirect = 1'b1;
    end else if (PCSrc == PC_JALR) begin
      target   = ALUResult & ~DATA_WIDTH'(1);
      redirect = 1'b1;
    end
  end

  // Next-PC and IF/ID control. Boot always captures the reset-vector word;
  // in run, redirect beats flush, which beats stall.
  always_comb begin
    pc_next       = pc_reg;
    if_load       = 1'b0;
    if_bubble     = 1'b0;
    misalign_next = 1'b0;
    if (state_reg == S_BOOT) begin
      pc_next = pc_plus4;
      if_load = 1'b1;
    end else if (redirect) begin
      pc_next       = target;
      if_bubble     = 1'b1;
      misalign_next = (target[1:0] != 2'b00);
    end else if (flush) begin
      pc_next   = stall ? pc_reg : pc_plus4;
      if_bubble = 1'b1;
    end else if (!stall) begin
      pc_next = pc_plus4;
      if_load = 1'b1;
    end
  end

  // FSM, PC register and registered misalign flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_BOOT;
      pc_reg    <= RESET_PC;
      Misalign  <= 1'b0;
    end else begin
      state_reg <= S_RUN;
      pc_reg    <= pc_next;
      Misalign  <= misalign_next;
    end
  end

  if_id_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .NOP_INSTR  (NOP_INSTR)
  ) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .load       (if_load),
    .bubble     (if_bubble),
    .instr_in   (IMemData),
    .pc_in      (pc_reg),
    .pcplus4_in (pc_plus4),
    .instr      (Instr_D),
    .pc         (PC_D),
    .pcplus4    (PCPlus4_D),
    .valid      (Valid_D)
  );

`ifdef FETCH_PERF_CNT_EN
  // Performance counters: real fetches and inserted bubbles (stalls excluded).
  always_ff @(posedge clk) begin
    if (rst) begin
      PerfFetched <= '0;
      PerfBubbles <= '0;
    end else begin
      if (if_load)   PerfFetched <= PerfFetched + DATA_WIDTH'(1);
      if (if_bubble) PerfBubbles <= PerfBubbles + DATA_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a directed vector table with
// hand-derived expectations, then randomized traffic compared each cycle
// against a behavioural reference model of the fetch rules.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  PCSrc;
  logic [31:0] ImmExt, ALUResult;
  logic        stall, flush;
  logic [31:0] IMemAddr, IMemData, Instr_D, PC_D, PCPlus4_D;
  logic        Valid_D, Misalign;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] PerfFetched, PerfBubbles;
`endif

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Instruction memory content: deterministic scramble of the address.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction
  assign IMemData = imem(IMemAddr);

  fetch_stage dut (
    .clk       (clk),
    .rst       (rst),
    .PCSrc     (PCSrc),
    .ImmExt    (ImmExt),
    .ALUResult (ALUResult),
    .stall     (stall),
    .flush     (flush),
    .IMemAddr  (IMemAddr),
    .IMemData  (IMemData),
    .Instr_D   (Instr_D),
    .PC_D      (PC_D),
    .PCPlus4_D (PCPlus4_D),
    .Valid_D   (Valid_D),
    .Misalign  (Misalign)
`ifdef FETCH_PERF_CNT_EN
    ,
    .PerfFetched (PerfFetched),
    .PerfBubbles (PerfBubbles)
`endif
  );

  // ---------------- reference model ----------------
  logic [31:0] m_pc, m_instr, m_pcd, m_pc4, m_fetched, m_bubbles;
  logic        m_valid, m_mis, m_boot;

  task automatic model_step(input logic r, input logic [1:0] src,
                            input logic [31:0] imm, input logic [31:0] alu,
                            input logic st, input logic fl);
    logic [31:0] tgt;
    logic        do_load, do_bub;
    do_load = 1'b0;
    do_bub  = 1'b0;
    if (r) begin
      m_pc = RST_PC; m_instr = NOP; m_pcd = 0; m_pc4 = 0;
      m_valid = 0; m_mis = 0; m_boot = 1; m_fetched = 0; m_bubbles = 0;
      return;
    end
    m_mis = 0;
    if (m_boot) begin
      do_load = 1'b1;
      m_boot  = 0;
    end else if (src == 2'd1 || src == 2'd2) begin
      tgt    = (src == 2'd1) ? m_pcd + imm : {alu[31:1], 1'b0};
      m_mis  = (tgt % 4) != 0;
      do_bub = 1'b1;
      m_pc   = tgt;
    end else if (fl) begin
      do_bub = 1'b1;
      if (!st) m_pc = m_pc + 4;
    end else if (!st) begin
      do_load = 1'b1;
    end
    if (do_load) begin
      m_instr = imem(m_pc); m_pcd = m_pc; m_pc4 = m_pc + 4; m_valid = 1;
      m_pc = m_pc + 4;
      m_fetched++;
    end
    if (do_bub) begin
      m_instr = NOP; m_valid = 0;
      m_bubbles++;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic r, input logic [1:0] src, input logic [31:0] imm,
                       input logic [31:0] alu, input logic st, input logic fl);
    @(negedge clk);
    rst = r; PCSrc = src; ImmExt = imm; ALUResult = alu; stall = st; flush = fl;
    model_step(r, src, imm, alu, st, fl);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".addr"},  IMemAddr,  m_pc);
    chk({tag, ".instr"}, Instr_D,   m_instr);
    chk({tag, ".pcd"},   PC_D,      m_pcd);
    chk({tag, ".pc4"},   PCPlus4_D, m_pc4);
    chk({tag, ".valid"}, 32'(Valid_D),  32'(m_valid));
    chk({tag, ".mis"},   32'(Misalign), 32'(m_mis));
`ifdef FETCH_PERF_CNT_EN
    chk({tag, ".pfetch"}, PerfFetched, m_fetched);
    chk({tag, ".pbub"},   PerfBubbles, m_bubbles);
`endif
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        r;
    logic [1:0]  src;
    logic [31:0] imm, alu;
    logic        st, fl;
    logic [31:0] e_addr, e_pcd;
    logic        e_valid, e_mis;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic r, input logic [1:0] src, input logic [31:0] imm,
                     input logic [31:0] alu, input logic st, input logic fl,
                     input logic [31:0] ea, input logic [31:0] ep,
                     input logic ev, input logic em);
    vec_t v;
    v.r = r; v.src = src; v.imm = imm; v.alu = alu; v.st = st; v.fl = fl;
    v.e_addr = ea; v.e_pcd = ep; v.e_valid = ev; v.e_mis = em;
    vq.push_back(v);
  endtask

  initial begin
    rst = 1; PCSrc = 0; ImmExt = 0; ALUResult = 0; stall = 0; flush = 0;

    //   rst src imm           alu           st fl  addr          pcd           v  mis
    add(1, 0, 0,            0,            0, 0, 32'hBFC00000, 32'h0,        0, 0);
    add(1, 0, 0,            0,            0, 0, 32'hBFC00000, 32'h0,        0, 0);
    add(0, 0, 0,            0,            0, 0, 32'hBFC00004, 32'hBFC00000, 1, 0);
    add(0, 0, 0,            0,            0, 0, 32'hBFC00008, 32'hBFC00004, 1, 0);
    add(0, 0, 0,            0,            0, 0, 32'hBFC0000C, 32'hBFC00008, 1, 0);
    add(0, 1, 32'hFFFFFFF8, 0,            0, 0, 32'hBFC00000, 32'hBFC00008, 0, 0);
    add(0, 0, 0,            0,            0, 0, 32'hBFC00004, 32'hBFC00000, 1, 0);
    add(0, 2, 0,            32'hBFC00101, 1, 0, 32'hBFC00100, 32'hBFC00000, 0, 0);
    add(0, 0, 0,            0,            0, 0, 32'hBFC00104, 32'hBFC00100, 1, 0);
    add(0, 2, 0,            32'hBFC00102, 0, 0, 32'hBFC00102, 32'hBFC00100, 0, 1);
    add(0, 0, 0,            0,            0, 0, 32'hBFC00106, 32'hBFC00102, 1, 0);
    add(0, 0, 0,            0,            1, 0, 32'hBFC00106, 32'hBFC00102, 1, 0);
    add(0, 0, 0,            0,            1, 0, 32'hBFC00106, 32'hBFC00102, 1, 0);
    add(0, 0, 0,            0,            1, 0, 32'hBFC00106, 32'hBFC00102, 1, 0);
    add(0, 0, 0,            0,            0, 1, 32'hBFC0010A, 32'hBFC00102, 0, 0);
    add(0, 0, 0,            0,            0, 0, 32'hBFC0010E, 32'hBFC0010A, 1, 0);
    add(0, 0, 0,            0,            1, 1, 32'hBFC0010E, 32'hBFC0010A, 0, 0);
    add(0, 1, 32'h00000010, 0,            0, 1, 32'hBFC0011A, 32'hBFC0010A, 0, 1);
    add(0, 2, 0,            32'hFFFFFFF8, 0, 0, 32'hFFFFFFF8, 32'hBFC0010A, 0, 0);
    add(0, 0, 0,            0,            0, 0, 32'hFFFFFFFC, 32'hFFFFFFF8, 1, 0);
    add(0, 0, 0,            0,            0, 0, 32'h00000000, 32'hFFFFFFFC, 1, 0);
    add(0, 0, 0,            0,            0, 0, 32'h00000004, 32'h00000000, 1, 0);
    add(0, 0, 0,            0,            0, 1, 32'h00000008, 32'h00000000, 0, 0);
    add(1, 2, 0,            32'h00001000, 1, 1, 32'hBFC00000, 32'h0,        0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      cycle(vq[i].r, vq[i].src, vq[i].imm, vq[i].alu, vq[i].st, vq[i].fl);
      chk($sformatf("vec%0d.addr", i),  IMemAddr, vq[i].e_addr);
      chk($sformatf("vec%0d.pcd", i),   PC_D,     vq[i].e_pcd);
      chk($sformatf("vec%0d.valid", i), 32'(Valid_D),  32'(vq[i].e_valid));
      chk($sformatf("vec%0d.mis", i),   32'(Misalign), 32'(vq[i].e_mis));
      chk($sformatf("vec%0d.instr", i), Instr_D, vq[i].e_valid ? imem(vq[i].e_pcd) : NOP);
      check_model($sformatf("vec%0d.model", i));
      $display("[TB] vec %0d rst=%0b src=%0d st=%0b fl=%0b addr=%08h pcd=%08h v=%0b mis=%0b",
               i, vq[i].r, vq[i].src, vq[i].st, vq[i].fl, IMemAddr, PC_D, Valid_D, Misalign);
    end

`ifdef FETCH_PERF_CNT_EN
    // Wrap sequence from FFFFFFF8: three fetches then one flush.
    cycle(0, 0, 0, 0, 0, 0);                       // boot fetch
    cycle(0, 2, 0, 32'hFFFFFFF8, 0, 0);            // redirect: bubble
    cycle(1, 0, 0, 0, 0, 0);                       // clear counters
    cycle(0, 0, 0, 0, 0, 0);                       // boot fetch -> C0004
    cycle(0, 2, 0, 32'hFFFFFFF8, 0, 0);            // 1 bubble
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("wrap.addr", IMemAddr, 32'h0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);
    chk("perf.fetched", PerfFetched, 32'd4);
    chk("perf.bubbles", PerfBubbles, 32'd2);
    $display("[TB] perf fetched=%0d bubbles=%0d", PerfFetched, PerfBubbles);
`endif

    // ---------------- randomized traffic vs model ----------------
    for (int n = 0; n < 400; n++) begin
      logic        r, st, fl;
      logic [1:0]  src;
      logic [31:0] imm, alu;
      int          sel;
      r   = (n < 2) || ($urandom_range(0, 49) == 0);
      sel = $urandom_range(0, 7);
      src = (sel == 5) ? 2'd1 : (sel == 6) ? 2'd2 : (sel == 7) ? 2'd3 : 2'd0;
      imm = ($urandom_range(0, 1) != 0) ? $urandom : 32'($signed($urandom_range(0, 63)) - 32);
      alu = $urandom;
      st  = ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 5) == 0);
      cycle(r, src, imm, alu, st, fl);
      check_model($sformatf("rnd%0d", n));
      $display("[TB] rnd %0d rst=%0b src=%0d st=%0b fl=%0b addr=%08h instr=%08h pcd=%08h v=%0b mis=%0b",
               n, r, src, st, fl, IMemAddr, Instr_D, PC_D, Valid_D, Misalign);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
